// File: rtl/qspi_arb_pkg.sv
// qspi_arb_pkg: shared definitions for the qspi line-transfer arbiter.
//   REQ_I/REQ_D/REQ_X : requester indices (bit positions in req/gnt vectors,
//                       also the round-robin pointer encoding)
//   state_e           : arbiter FSM states
//   tag_w()           : line tag width from address width and line length
package qspi_arb_pkg;

    localparam logic [1:0] REQ_I = 2'd0;
    localparam logic [1:0] REQ_D = 2'd1;
    localparam logic [1:0] REQ_X = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic int unsigned tag_w(input int unsigned pa,
                                          input int unsigned line_length);
        return pa - $clog2(line_length);
    endfunction

endpackage

// File: rtl/qspi_arb_rr_pick3.sv
// rr_pick3: combinational three-way round-robin picker.
//   req_i   [2:0] pending requests, bit index = REQ_I/REQ_D/REQ_X
//   ptr_i   [1:0] last winner; search starts at ptr_i+1 and wraps I->D->X->I
//   win_o   [2:0] one-hot winner (zero when nothing pending)
//   valid_o       at least one request pending
module rr_pick3
    import qspi_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] win_o,
    output logic       valid_o
);

    logic [1:0] order [3];

    // Search order is the rotation that places the last winner last.
    always_comb begin
        win_o = 3'b000;
        case (ptr_i)
            REQ_I:   order = '{REQ_D, REQ_X, REQ_I};
            REQ_D:   order = '{REQ_X, REQ_I, REQ_D};
            default: order = '{REQ_I, REQ_D, REQ_X};
        endcase
        for (int k = 0; k < 3; k++) begin
            if (win_o == 3'b000 && req_i[order[k]]) begin
                win_o[order[k]] = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/qspi_arb.sv
// qspi_arb: shares the qspi line-transfer engine between icache (I),
// dcache (D) and an auxiliary line mover (X). Round-robin, one whole line
// transfer per grant, with a one-cycle quiet gap between transfers.
//   clk, reset                 clock, synchronous active-high reset
//   i_req/i_tag/i_mem          icache fill request (always a read)
//   d_req/d_write/d_tag/d_mem  dcache fill or writeback request
//   x_req/x_write/x_tag/x_mem  aux mover request
//   q_done                     qspi transfer-complete pulse
//   q_req/q_i_d/q_write/q_paddr/q_mem  registered request to qspi
//   i_gnt/d_gnt/x_gnt          registered one-hot grant
//   i_done/d_done/x_done       completion pulses (combinational)
//   err                        watchdog abort pulse
// Optional: define ARB_TIMEOUT_EN to build the BUSY watchdog (TIMEOUT cycles).
module qspi_arb
    import qspi_arb_pkg::*;
#(
    parameter int unsigned PA          = 24,
    parameter int unsigned LINE_LENGTH = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_req,
    input  logic [tag_w(PA, LINE_LENGTH)-1:0]   i_tag,
    input  logic [1:0]                          i_mem,
    input  logic                                d_req,
    input  logic                                d_write,
    input  logic [tag_w(PA, LINE_LENGTH)-1:0]   d_tag,
    input  logic [1:0]                          d_mem,
    input  logic                                x_req,
    input  logic                                x_write,
    input  logic [tag_w(PA, LINE_LENGTH)-1:0]   x_tag,
    input  logic [1:0]                          x_mem,
    input  logic                                q_done,
    output logic                                q_req,
    output logic                                q_i_d,
    output logic                                q_write,
    output logic [tag_w(PA, LINE_LENGTH)-1:0]   q_paddr,
    output logic [1:0]                          q_mem,
    output logic                                i_gnt,
    output logic                                d_gnt,
    output logic                                x_gnt,
    output logic                                i_done,
    output logic                                d_done,
    output logic                                x_done,
    output logic                                err
);

    localparam int unsigned TW = tag_w(PA, LINE_LENGTH);

    // Watchdog counter is 8 bits wide.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("qspi_arb: TIMEOUT must be in 1..255");
    end

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [2:0]      gnt_q, gnt_d;
    logic            req_q, req_d;
    logic            i_d_q, i_d_d;
    logic            write_q, write_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic [1:0]      mem_q, mem_d;

    logic [2:0]      req_vec;
    logic [2:0]      win;
    logic            win_valid;
    logic            timeout_hit;
    logic            xfer_end;

    assign req_vec = {x_req, d_req, i_req};

    rr_pick3 u_pick (
        .req_i   (req_vec),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Zero outside BUSY, so the first BUSY cycle sees 0 and the
    // TIMEOUT-th BUSY cycle sees TIMEOUT-1.
    assign cnt_d       = (state_q == ST_BUSY) ? cnt_q + 8'd1 : 8'd0;
    assign timeout_hit = (state_q == ST_BUSY) && (cnt_q == 8'(TIMEOUT - 1));
    assign err         = timeout_hit && !q_done;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // q_done is only meaningful while a transfer is in flight.
    assign xfer_end = (state_q == ST_BUSY) && (q_done || timeout_hit);

    assign i_done = xfer_end && gnt_q[REQ_I];
    assign d_done = xfer_end && gnt_q[REQ_D];
    assign x_done = xfer_end && gnt_q[REQ_X];

    // Next-state: arbitrate in IDLE and GAP, hold everything during BUSY.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        i_d_d   = i_d_q;
        write_d = write_q;
        tag_d   = tag_q;
        mem_d   = mem_q;
        case (state_q)
            ST_BUSY: begin
                if (xfer_end) begin
                    state_d = ST_GAP;
                    gnt_d   = 3'b000;
                    req_d   = 1'b0;
                    i_d_d   = 1'b0;
                    write_d = 1'b0;
                    tag_d   = '0;
                    mem_d   = 2'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
                req_d   = 1'b0;
                i_d_d   = 1'b0;
                write_d = 1'b0;
                tag_d   = '0;
                mem_d   = 2'd0;
                if (win_valid) begin
                    state_d = ST_BUSY;
                    gnt_d   = win;
                    req_d   = 1'b1;
                    if (win[REQ_I]) begin
                        ptr_d   = REQ_I;
                        i_d_d   = 1'b1;
                        tag_d   = i_tag;
                        mem_d   = i_mem;
                    end else if (win[REQ_D]) begin
                        ptr_d   = REQ_D;
                        write_d = d_write;
                        tag_d   = d_tag;
                        mem_d   = d_mem;
                    end else begin
                        ptr_d   = REQ_X;
                        write_d = x_write;
                        tag_d   = x_tag;
                        mem_d   = x_mem;
                    end
                end
            end
        endcase
    end

    // Pointer resets to X so I has first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= REQ_X;
            gnt_q   <= 3'b000;
            req_q   <= 1'b0;
            i_d_q   <= 1'b0;
            write_q <= 1'b0;
            tag_q   <= '0;
            mem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            i_d_q   <= i_d_d;
            write_q <= write_d;
            tag_q   <= tag_d;
            mem_q   <= mem_d;
        end
    end

    assign q_req   = req_q;
    assign q_i_d   = i_d_q;
    assign q_write = write_q;
    assign q_paddr = tag_q;
    assign q_mem   = mem_q;
    assign i_gnt   = gnt_q[REQ_I];
    assign d_gnt   = gnt_q[REQ_D];
    assign x_gnt   = gnt_q[REQ_X];

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: directed, table-driven bench for qspi_arb.
module tb_qspi_arb;

    localparam int unsigned PA  = 24;
    localparam int unsigned LL  = 4;
    localparam int unsigned TW  = PA - 2;
    localparam int unsigned TMO = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, x_req;
    logic          d_write, x_write;
    logic [TW-1:0] i_tag, d_tag, x_tag;
    logic [1:0]    i_mem, d_mem, x_mem;
    logic          q_done;
    logic          q_req, q_i_d, q_write;
    logic [TW-1:0] q_paddr;
    logic [1:0]    q_mem;
    logic          i_gnt, d_gnt, x_gnt;
    logic          i_done, d_done, x_done;
    logic          err;

    logic [2:0]    gnt_v, done_v;
    assign gnt_v  = {x_gnt, d_gnt, i_gnt};
    assign done_v = {x_done, d_done, i_done};

    int tests = 0;
    int fails = 0;
    int err_cnt;

    qspi_arb #(.PA(PA), .LINE_LENGTH(LL), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_tag   (i_tag),
        .i_mem   (i_mem),
        .d_req   (d_req),
        .d_write (d_write),
        .d_tag   (d_tag),
        .d_mem   (d_mem),
        .x_req   (x_req),
        .x_write (x_write),
        .x_tag   (x_tag),
        .x_mem   (x_mem),
        .q_done  (q_done),
        .q_req   (q_req),
        .q_i_d   (q_i_d),
        .q_write (q_write),
        .q_paddr (q_paddr),
        .q_mem   (q_mem),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt),
        .x_gnt   (x_gnt),
        .i_done  (i_done),
        .d_done  (d_done),
        .x_done  (x_done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] prime;    // requester served first to set the pointer (0 = none)
        logic [2:0] reqs;     // simultaneous requests {x,d,i}
        logic [2:0] exp_gnt;  // expected one-hot winner
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_reqs(input logic [2:0] r);
        i_req = r[0];
        d_req = r[1];
        x_req = r[2];
    endtask

    task automatic clear_inputs();
        set_reqs(3'b000);
        d_write = 1'b0; x_write = 1'b0;
        i_tag = '0; d_tag = '0; x_tag = '0;
        i_mem = 2'd0; d_mem = 2'd0; x_mem = 2'd0;
        q_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, 32'({q_req, q_i_d, q_write, q_mem, gnt_v, done_v, err}), 32'd0);
        chk({name, "_paddr"}, 32'(q_paddr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // prime, simultaneous reqs {x,d,i}, expected winner
        vecs[0]  = '{3'b000, 3'b011, 3'b001};
        vecs[1]  = '{3'b000, 3'b110, 3'b010};
        vecs[2]  = '{3'b000, 3'b100, 3'b100};
        vecs[3]  = '{3'b001, 3'b101, 3'b100};
        vecs[4]  = '{3'b001, 3'b111, 3'b010};
        vecs[5]  = '{3'b001, 3'b001, 3'b001};
        vecs[6]  = '{3'b010, 3'b011, 3'b001};
        vecs[7]  = '{3'b010, 3'b111, 3'b100};
        vecs[8]  = '{3'b010, 3'b010, 3'b010};
        vecs[9]  = '{3'b100, 3'b111, 3'b001};
        vecs[10] = '{3'b100, 3'b110, 3'b010};

        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_all_zero("reset");

        // q_done while idle is ignored
        q_done = 1'b1;
        #1;
        chk("idle_qdone_done", 32'(done_v), 32'd0);
        step();
        q_done = 1'b0;
        chk("idle_qdone_req", 32'(q_req), 32'd0);

        // Single I transfer
        i_req = 1'b1; i_tag = TW'(24'h1234); i_mem = 2'd2;
        step();
        chk("t1_gnt", 32'(gnt_v), 32'b001);
        chk("t1_qreq", 32'(q_req), 32'd1);
        chk("t1_qid", 32'(q_i_d), 32'd1);
        chk("t1_paddr", 32'(q_paddr), 32'h1234);
        chk("t1_mem", 32'(q_mem), 32'd2);
        chk("t1_write", 32'(q_write), 32'd0);
        repeat (4) step();
        chk("t1_busy_hold", 32'({q_req, gnt_v}), 32'b1001);
        chk("t1_no_early_done", 32'(done_v), 32'd0);
        q_done = 1'b1;
        #1;
        chk("t1_done", 32'(done_v), 32'b001);
        step();
        q_done = 1'b0; i_req = 1'b0;
        chk("t1_gap", 32'({q_req, gnt_v}), 32'd0);
        step();
        chk("t1_idle", 32'({q_req, gnt_v}), 32'd0);

        // I, D, X rise together: served in order with a gap between each
        clear_inputs();
        do_reset();
        d_write = 1'b1; x_write = 1'b0;
        d_tag = TW'(24'h0200); x_tag = TW'(24'h0300); i_tag = TW'(24'h0100);
        set_reqs(3'b111);
        step();
        chk("t2_g1", 32'(gnt_v), 32'b001);
        step();
        q_done = 1'b1;
        #1;
        chk("t2_done1", 32'(done_v), 32'b001);
        step();
        q_done = 1'b0; i_req = 1'b0;
        chk("t2_gap1", 32'({q_req, gnt_v}), 32'd0);
        step();
        chk("t2_g2", 32'(gnt_v), 32'b010);
        chk("t2_g2_ctl", 32'({q_req, q_i_d, q_write}), 32'b101);
        chk("t2_g2_paddr", 32'(q_paddr), 32'h0200);
        q_done = 1'b1;
        step();
        q_done = 1'b0; d_req = 1'b0;
        chk("t2_gap2", 32'({q_req, gnt_v}), 32'd0);
        step();
        chk("t2_g3", 32'(gnt_v), 32'b100);
        chk("t2_g3_ctl", 32'({q_req, q_i_d, q_write}), 32'b100);
        q_done = 1'b1;
        #1;
        chk("t2_done3", 32'(done_v), 32'b100);
        step();
        q_done = 1'b0; x_req = 1'b0;
        step();
        chk("t2_idle", 32'({q_req, gnt_v}), 32'd0);

        // Latched tag holds while the requester input changes / drops
        clear_inputs();
        do_reset();
        d_req = 1'b1; d_tag = TW'(24'h0040); d_mem = 2'd1;
        step();
        chk("t3_paddr0", 32'(q_paddr), 32'h0040);
        d_tag = TW'(24'h0FFF); d_mem = 2'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_paddr_hold", 32'({q_mem, q_paddr}), 32'({2'd1, TW'(24'h0040)}));
        end
        d_req = 1'b0;
        step();
        chk("t3_dropped_gnt", 32'(gnt_v), 32'b010);
        q_done = 1'b1;
        #1;
        chk("t3_done", 32'(done_v), 32'b010);
        chk("t3_paddr_last", 32'(q_paddr), 32'h0040);
        step();
        q_done = 1'b0;
        step();

        // Reset during BUSY, then a normal X grant
        clear_inputs();
        do_reset();
        x_req = 1'b1; x_tag = TW'(24'h0ABC); x_mem = 2'd3; x_write = 1'b1;
        step();
        chk("t4_busy", 32'(gnt_v), 32'b100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("t4_midreset");
        step();
        chk("t4_regrant", 32'(gnt_v), 32'b100);
        chk("t4_regrant_pay", 32'({q_req, q_write, q_mem, q_paddr}), 32'({1'b1, 1'b1, 2'd3, TW'(24'h0ABC)}));
        x_req = 1'b0; q_done = 1'b1;
        step();
        q_done = 1'b0;
        step();

        // Table-driven round-robin pointer checks
        for (int v = 0; v < 11; v++) begin
            clear_inputs();
            do_reset();
            if (vecs[v].prime != 3'b000) begin
                set_reqs(vecs[v].prime);
                step();
                set_reqs(3'b000);
                q_done = 1'b1;
                step();
                q_done = 1'b0;
                step();
            end
            d_write = 1'b1; x_write = 1'b1;
            set_reqs(vecs[v].reqs);
            step();
            chk($sformatf("rr%0d_gnt", v), 32'(gnt_v), 32'(vecs[v].exp_gnt));
            chk($sformatf("rr%0d_qreq", v), 32'(q_req), 32'd1);
            chk($sformatf("rr%0d_qid", v), 32'(q_i_d), 32'(vecs[v].exp_gnt[0]));
            chk($sformatf("rr%0d_write", v), 32'(q_write), 32'(!vecs[v].exp_gnt[0]));
            set_reqs(3'b000);
            q_done = 1'b1;
            #1;
            chk($sformatf("rr%0d_done", v), 32'(done_v), 32'(vecs[v].exp_gnt));
            step();
            q_done = 1'b0;
            step();
        end

        // Watchdog
        clear_inputs();
        do_reset();
`ifdef ARB_TIMEOUT_EN
        d_req = 1'b1;
        step();
        i_req = 1'b1; i_tag = TW'(24'h0777);
        for (int k = 1; k <= int'(TMO); k++) begin
            if (k > 1) step();
            chk($sformatf("to_err_c%0d", k), 32'(err), 32'(k == int'(TMO)));
        end
        chk("to_d_done", 32'(done_v), 32'b010);
        d_req = 1'b0;
        step();
        chk("to_gap", 32'({q_req, gnt_v, err}), 32'd0);
        step();
        chk("to_next_i", 32'(gnt_v), 32'b001);
        chk("to_next_paddr", 32'(q_paddr), 32'h0777);
        i_req = 1'b0; q_done = 1'b1;
        step();
        q_done = 1'b0;
        step();
`else
        d_req = 1'b1;
        step();
        err_cnt = 0;
        repeat (1000) begin
            if (err !== 1'b0) err_cnt++;
            step();
        end
        chk("noto_err", 32'(err_cnt), 32'd0);
        chk("noto_still_busy", 32'({q_req, gnt_v}), 32'b1010);
        d_req = 1'b0; q_done = 1'b1;
        #1;
        chk("noto_done", 32'(done_v), 32'b010);
        step();
        q_done = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qspi_arb.md
Name: qspi_arb

Overview:
- Sequences and shares the single qspi line-transfer engine between three requesters:
  - I: icache line fill
  - D: dcache fill or writeback
  - X: auxiliary line-mover, e.g. boot/DMA copy
- Sits between the caches/aux mover and qspi. Drives qspi req, i_d, write, mem and paddr.
- Round-robin arbitration. Each grant is held for exactly one whole line transfer, with a forced one-cycle quiet gap between transfers.

Parameters:
- PA, 24, physical address width.
- LINE_LENGTH, 4, cache line length in bytes; the tag is PA-1:$clog2(LINE_LENGTH).
- TIMEOUT, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  icache line fill request; held until i_done.
- i_tag  in  PA-$clog2(LINE_LENGTH)  icache line tag.
- i_mem  in  2  icache target device select.
- d_req  in  1  dcache request; held until d_done.
- d_write  in  1  dcache direction: 1=push (writeback), 0=pull (fill).
- d_tag  in  PA-$clog2(LINE_LENGTH)  dcache line tag.
- d_mem  in  2  dcache target device select.
- x_req, x_write, x_tag, x_mem  in  1/1/tag/2  aux requester; same meaning as the d_ signals.
- q_done  in  1  qspi single-cycle pulse: line transfer complete.
- q_req  out  1  request to qspi.
- q_i_d  out  1  1 = instruction-side transfer.
- q_write  out  1  transfer direction.
- q_paddr  out  tag  line tag to qspi.
- q_mem  out  2  device select to qspi.
- i_gnt, d_gnt, x_gnt  out  1 each  one-hot grant.
- i_done, d_done, x_done  out  1 each  completion pulses.
- err  out  1  watchdog abort pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer=X (so I has first priority).
- Reset mid-transfer: the transfer is abandoned at once and all outputs return to 0.
- States:
  - IDLE: q_req=0. If any req is pending, pick a winner, register grant, go to BUSY.
  - BUSY: q_req=1 and the winner's gnt=1. On q_done, go to GAP.
  - GAP: exactly one cycle with q_req=0 and all gnt=0. Arbitration runs here too: if any req is pending, go to BUSY with the new winner, else go to IDLE.
- Latency:
  - Request seen in IDLE at cycle n gives gnt and q_req at n+1.
  - q_done at cycle m gives done at m (combinational: q_done & gnt), GAP at m+1, next grant at m+2.
- Pick order: starts at pointer+1 and wraps I→D→X→I. The pointer updates to the winner at grant time. Any waiting requester is served within 2 foreign transfers.
- Latching: tag, mem and write are registered from the winner at grant time and held stable through BUSY. Requester inputs are ignored while BUSY.
- q_i_d=1 only when I is granted. q_write=0 for I.
- Requests dropped while granted are ignored; the transfer completes and done still pulses.
- q_done outside BUSY is ignored.
- Simultaneous requests: the pointer decides. Example: pointer=X with I and D both pending means I wins.
- A request rising in the same cycle as q_done is eligible in GAP.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without q_done: err and the granted done pulse together for one cycle, then go to GAP.
  - The requester must check err to discard the data.
- Not defined: no counter is built, err is tied 0, and BUSY waits forever.

Decomposition:
- Shared package qspi_arb_pkg:
  - REQ_I=0, REQ_D=1, REQ_X=2.
  - State encodings ST_IDLE, ST_BUSY, ST_GAP.
  - TAG_W function of PA and LINE_LENGTH.
- One natural sub-module: rr_pick3 (combinational). Takes the 3-bit req vector and 2-bit pointer; returns a one-hot winner and a valid flag.

Test Plan:
- Reset, then i_req=1 with i_tag=0x1234 → next cycle i_gnt=1, q_req=1, q_i_d=1, q_paddr=0x1234. q_done 5 cycles later → i_done that cycle, then GAP, then IDLE.
- i_req, d_req(d_write=1) and x_req all rise together → grants in order I, D, X. Each grant starts 2 cycles after the previous q_done, and q_req=0 in each gap cycle.
- Change d_tag from 0x0040 to 0x0FFF mid-BUSY → q_paddr stays 0x0040 until q_done.
- Assert reset during BUSY → next cycle all outputs are 0. A later x_req is granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT=10, grant D and withhold q_done → err=d_done=1 on the 10th BUSY cycle, then a pending I is granted. Without the macro, err stays 0 for 1000 cycles.
